// File: rtl/state_decoder_if.sv
// state_decoder_if: serial state link receive-side bundle.
// Ports: in (serial line), stateOut/dataValid/frameErr/busy (decoded results).
interface state_decoder_if #(
    parameter int STATE_LENGTH = 7
);
    logic                    in;
    logic [STATE_LENGTH-1:0] stateOut;
    logic                    dataValid;
    logic                    frameErr;
    logic                    busy;

    modport master (
        output in,
        input  stateOut, dataValid, frameErr, busy
    );

    modport slave (
        input  in,
        output stateOut, dataValid, frameErr, busy
    );
endinterface

// File: rtl/state_decoder.sv
// state_decoder: recovers the state vector from the serial state link,
// with framing checks. Ports: clk, rstN (async low), link (slave modport).
// Optional: STATE_DECODER_SYNC_EN adds a 2-flop input synchronizer.
module state_decoder #(
    parameter int STATE_LENGTH      = 7,
    parameter int HEADER_ON_COUNTS  = 3,
    parameter int HEADER_OFF_COUNTS = 3,
    parameter int CLOSER_ON_COUNTS  = 2
) (
    input logic            clk,
    input logic            rstN,
    state_decoder_if.slave link
);
    typedef enum logic [2:0] {
        RESYNC, IDLE, HDR_ON, HDR_OFF,
        BITS, CLS_GAP, CLS_ON, CLS_END
    } state_t;

    localparam logic [4:0] HON   = 5'(HEADER_ON_COUNTS);
    // HDR_OFF is entered with the first low already consumed
    localparam logic [4:0] HOFF1 = 5'(HEADER_OFF_COUNTS - 1);
    localparam logic [4:0] CON1  = 5'(CLOSER_ON_COUNTS - 1);
    localparam logic [4:0] IDX0  = 5'(STATE_LENGTH - 1);

    state_t                  state_q;
    logic [4:0]              cnt_q;
    logic [4:0]              idx_q;
    logic [1:0]              slot_q;
    logic [STATE_LENGTH-1:0] shift_q;
    logic [STATE_LENGTH-1:0] state_out_q;
    logic                    valid_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    line;

`ifdef STATE_DECODER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) sync_q <= '0;
        else       sync_q <= {sync_q[0], link.in};
    end

    assign line = sync_q[1];
`else
    assign line = link.in;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= RESYNC;
            cnt_q       <= '0;
            idx_q       <= '0;
            slot_q      <= '0;
            shift_q     <= '0;
            state_out_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                // waits for a low so a high in a low slot is not re-framed
                RESYNC: if (!line) state_q <= IDLE;
                IDLE: begin
                    if (line) begin
                        state_q <= HDR_ON;
                        cnt_q   <= 5'd1;
                        busy_q  <= 1'b1;
                    end
                end
                HDR_ON: begin
                    if (line) begin
                        if (cnt_q == HON) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= RESYNC;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end else if (cnt_q == HON) begin
                        state_q <= HDR_OFF;
                        cnt_q   <= 5'd1;
                    end else begin
                        // short high: glitch, not an error
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HDR_OFF: begin
                    if (line) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= RESYNC;
                    end else if (cnt_q == HOFF1) begin
                        state_q <= BITS;
                        slot_q  <= '0;
                        idx_q   <= IDX0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                BITS: begin
                    case (slot_q)
                        2'd0: begin
                            if (line) begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= RESYNC;
                            end else begin
                                slot_q <= 2'd1;
                            end
                        end
                        2'd1: begin
                            // MSB first: shifting left lands bit idx in place
                            shift_q <= {shift_q[STATE_LENGTH-2:0], line};
                            slot_q  <= 2'd2;
                        end
                        2'd2: begin
                            if (line) begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= RESYNC;
                            end else begin
                                slot_q <= 2'd0;
                                if (idx_q == 5'd0) state_q <= CLS_GAP;
                                else               idx_q   <= idx_q - 5'd1;
                            end
                        end
                        default: slot_q <= 2'd0;
                    endcase
                end
                CLS_GAP: begin
                    if (line) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= RESYNC;
                    end else begin
                        state_q <= CLS_ON;
                        cnt_q   <= '0;
                    end
                end
                CLS_ON: begin
                    if (!line) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= RESYNC;
                    end else if (cnt_q == CON1) begin
                        state_q <= CLS_END;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                CLS_END: begin
                    busy_q  <= 1'b0;
                    if (line) begin
                        err_q   <= 1'b1;
                        state_q <= RESYNC;
                    end else begin
                        state_out_q <= shift_q;
                        valid_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= RESYNC;
                end
            endcase
        end
    end

    assign link.stateOut  = state_out_q;
    assign link.dataValid = valid_q;
    assign link.frameErr  = err_q;
    assign link.busy      = busy_q;
endmodule
